// File: rtl/can_stuff_ctrl_if.sv
// Sample-side and decoder-side signals of the CAN bit-stuffing sequencer.
// The sampler/checker side uses master; the sequencer itself uses slave.
interface can_stuff_ctrl_if;
  logic       SP;
  logic       RX;
  logic       STF_ERR;
  logic       F_STF;
  logic       STUFF_BIT;
  logic       BIT_VALID;
  logic       BIT_OUT;
  logic [6:0] BIT_IDX;
  logic       IDE_OUT;
  logic [3:0] DLC;
  logic       FRAME_OK;
  logic       ERR;
  logic       BUSY;

  modport master (
    output SP, RX, STF_ERR,
    input  F_STF, STUFF_BIT, BIT_VALID, BIT_OUT, BIT_IDX,
           IDE_OUT, DLC, FRAME_OK, ERR, BUSY
  );

  modport slave (
    input  SP, RX, STF_ERR,
    output F_STF, STUFF_BIT, BIT_VALID, BIT_OUT, BIT_IDX,
           IDE_OUT, DLC, FRAME_OK, ERR, BUSY
  );
endinterface

// File: rtl/can_stuff_ctrl.sv
// CAN frame sequencer for the destuffing path: tracks bus idle, SOF and field
// positions, removes stuff bits, and gates the stuff-error checker.
module can_stuff_ctrl #(
  parameter int IDLE_BITS = 11,
  parameter int TAIL_BITS = 10,
  parameter int ERR_HOLD  = 6
) (
  input logic             clk,
  input logic             reset,
  can_stuff_ctrl_if.slave bus
);
  localparam int CNT_MAX = (IDLE_BITS > TAIL_BITS)
                           ? ((IDLE_BITS > ERR_HOLD) ? IDLE_BITS : ERR_HOLD)
                           : ((TAIL_BITS > ERR_HOLD) ? TAIL_BITS : ERR_HOLD);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] STUFFED   = 3'd2;
  localparam logic [2:0] TAIL      = 3'd3;
  localparam logic [2:0] ERROR     = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       idx;
  logic [2:0]       run;
  logic             last;
  logic             crc_done;
  logic             rtr_q;
  logic             ide_q;
  logic [3:0]       dlc_q;
  logic             stuff_bit_q;
  logic             bit_valid_q;
  logic             bit_out_q;
  logic             frame_ok_q;
  logic             err_q;

  logic [6:0] idx_inc;
  logic [2:0] run_nxt;
  logic [6:0] crc_last;
  logic [6:0] dlc_base;
  logic [6:0] dlc_off;
  logic       in_dlc;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  // Index of the final CRC bit, from the header fields latched so far.
  function automatic logic [6:0] crc_last_idx(input logic ide, input logic rtr,
                                              input logic [3:0] dlc);
    logic [3:0] n;
    n = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
    return (ide ? 7'd53 : 7'd33) + {n, 3'b000};
  endfunction

  assign idx_inc  = sat_inc(idx);
  assign run_nxt  = (bus.RX == last) ? run + 3'd1 : 3'd1;
  assign crc_last = crc_last_idx(ide_q, rtr_q, dlc_q);
  assign dlc_base = ide_q ? 7'd35 : 7'd15;
  assign dlc_off  = idx_inc - dlc_base;
  assign in_dlc   = (dlc_off < 7'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_IDLE;
      cnt         <= '0;
      idx         <= '0;
      run         <= '0;
      last        <= 1'b0;
      crc_done    <= 1'b0;
      rtr_q       <= 1'b0;
      ide_q       <= 1'b0;
      dlc_q       <= '0;
      stuff_bit_q <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      stuff_bit_q <= 1'b0;
      bit_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_q       <= 1'b0;
      // An external stuff error wins over, and swallows, a coincident sample.
      if (state == STUFFED && bus.STF_ERR) begin
        state    <= ERROR;
        cnt      <= '0;
        crc_done <= 1'b0;
        err_q    <= 1'b1;
      end else if (bus.SP) begin
        case (state)
          WAIT_IDLE: begin
            if (!bus.RX) begin
              cnt <= '0;
            end else if (cnt == CNT_W'(IDLE_BITS - 1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          IDLE: begin
            if (!bus.RX) begin
              state       <= STUFFED;
              idx         <= '0;
              run         <= 3'd1;
              last        <= 1'b0;
              crc_done    <= 1'b0;
              bit_valid_q <= 1'b1;
              bit_out_q   <= 1'b0;
            end
          end
          STUFFED: begin
            if (run == 3'd5) begin
              if (bus.RX != last) begin
                stuff_bit_q <= 1'b1;
                run         <= 3'd1;
                last        <= bus.RX;
                if (crc_done) begin
                  state    <= TAIL;
                  cnt      <= '0;
                  crc_done <= 1'b0;
                end
              end else begin
                state    <= ERROR;
                cnt      <= '0;
                crc_done <= 1'b0;
                err_q    <= 1'b1;
              end
            end else begin
              run         <= run_nxt;
              last        <= bus.RX;
              idx         <= idx_inc;
              bit_valid_q <= 1'b1;
              bit_out_q   <= bus.RX;
              // Index 12 is SRR in extended frames; RTR is overwritten at 32.
              if (idx_inc == 7'd12) rtr_q <= bus.RX;
              if (idx_inc == 7'd13) ide_q <= bus.RX;
              if (ide_q && idx_inc == 7'd32) rtr_q <= bus.RX;
              if (in_dlc) dlc_q[~dlc_off[1:0]] <= bus.RX;
              if (idx_inc == crc_last) begin
                if (run_nxt == 3'd5) begin
                  crc_done <= 1'b1;
                end else begin
                  state <= TAIL;
                  cnt   <= '0;
                end
              end
            end
          end
          TAIL: begin
            idx         <= idx_inc;
            bit_valid_q <= 1'b1;
            bit_out_q   <= bus.RX;
            if (cnt == CNT_W'(TAIL_BITS - 1)) begin
              frame_ok_q <= 1'b1;
              state      <= IDLE;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ERROR: begin
            if (cnt == CNT_W'(ERR_HOLD - 1)) begin
              state <= WAIT_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= WAIT_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.F_STF     = (state == STUFFED);
  assign bus.BUSY      = (state == STUFFED) || (state == TAIL) || (state == ERROR);
  assign bus.STUFF_BIT = stuff_bit_q;
  assign bus.BIT_VALID = bit_valid_q;
  assign bus.BIT_OUT   = bit_out_q;
  assign bus.BIT_IDX   = idx;
  assign bus.IDE_OUT   = ide_q;
  assign bus.DLC       = dlc_q;
  assign bus.FRAME_OK  = frame_ok_q;
  assign bus.ERR       = err_q;
endmodule

// File: tb/tb_can_stuff_ctrl.sv
// Bench for can_stuff_ctrl: frames are built field by field, stuffed the way a
// transmitter would, then fed bit by bit while every decoder output is compared.
module tb_can_stuff_ctrl;
  localparam int IDLE_BITS = 11;
  localparam int TAIL_BITS = 10;
  localparam int ERR_HOLD  = 6;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  can_stuff_ctrl_if bus ();

  can_stuff_ctrl #(
    .IDLE_BITS(IDLE_BITS),
    .TAIL_BITS(TAIL_BITS),
    .ERR_HOLD (ERR_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference frame: unstuffed bits, stuffed stream, stuff flags, frame index.
  bit fr_u[$];
  bit fr_s[$];
  bit fr_stf[$];
  int fr_idx[$];
  int fr_last;
  bit fr_ide;
  int fr_dlc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) fr_u.push_back(v[i]);
  endtask

  task automatic build_frame(input bit ide, input bit rtr, input int dlc,
                             input logic [28:0] id, input logic [63:0] data,
                             input logic [14:0] crc);
    int n;
    int run;
    bit prev;
    bit b;
    fr_u.delete(); fr_s.delete(); fr_stf.delete(); fr_idx.delete();
    fr_ide = ide;
    fr_dlc = dlc;
    n = rtr ? 0 : ((dlc > 8) ? 8 : dlc);
    fr_u.push_back(1'b0);
    if (!ide) begin
      push_bits(32'(id[10:0]), 11);
      fr_u.push_back(rtr);
      fr_u.push_back(1'b0);
      fr_u.push_back(1'b0);
    end else begin
      push_bits(32'(id[28:18]), 11);
      fr_u.push_back(1'b1);
      fr_u.push_back(1'b1);
      push_bits(32'(id[17:0]), 18);
      fr_u.push_back(rtr);
      fr_u.push_back(1'b0);
      fr_u.push_back(1'b0);
    end
    push_bits(32'(dlc), 4);
    for (int i = 0; i < 8 * n; i++) fr_u.push_back(data[63 - i]);
    push_bits(32'(crc), 15);
    fr_last = fr_u.size() - 1;
    // Transmitter view: after five equal bits insert the complement.
    run  = 0;
    prev = 1'b0;
    for (int i = 0; i < fr_u.size(); i++) begin
      b = fr_u[i];
      fr_s.push_back(b); fr_stf.push_back(1'b0); fr_idx.push_back(i);
      if (run > 0 && b == prev) run++;
      else begin run = 1; prev = b; end
      if (run == 5) begin
        fr_s.push_back(~b); fr_stf.push_back(1'b1); fr_idx.push_back(i);
        prev = ~b;
        run  = 1;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.RX = b;
    bus.SP = 1'b1;
    @(posedge clk);
    #1;
    bus.SP = 1'b0;
  endtask

  task automatic go_idle();
    repeat (IDLE_BITS) send_bit(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_stf"},     bus.F_STF, 0);
    chk({tag, "_stuff_bit"}, bus.STUFF_BIT, 0);
    chk({tag, "_bit_valid"}, bus.BIT_VALID, 0);
    chk({tag, "_bit_out"},   bus.BIT_OUT, 0);
    chk({tag, "_bit_idx"},   bus.BIT_IDX, 0);
    chk({tag, "_ide_out"},   bus.IDE_OUT, 0);
    chk({tag, "_dlc"},       bus.DLC, 0);
    chk({tag, "_frame_ok"},  bus.FRAME_OK, 0);
    chk({tag, "_err"},       bus.ERR, 0);
    chk({tag, "_busy"},      bus.BUSY, 0);
  endtask

  task automatic err_recover();
    for (int i = 0; i < ERR_HOLD; i++) begin
      send_bit(1'b1);
      chk("hold_busy", bus.BUSY, (i < ERR_HOLD - 1));
      chk("hold_err", bus.ERR, 0);
      chk("hold_valid", bus.BIT_VALID, 0);
      chk("hold_f_stf", bus.F_STF, 0);
    end
    repeat (IDLE_BITS - 1) send_bit(1'b1);
    send_bit(1'b0);
    chk("early_sof_valid", bus.BIT_VALID, 0);
    chk("early_sof_busy", bus.BUSY, 0);
    go_idle();
  endtask

  // err_at: stuffed-stream position to corrupt; stf_idx: frame index after
  // which STF_ERR is pulsed; noise: STF_ERR held high in IDLE and TAIL.
  task automatic run_frame(input int err_at, input int stf_idx, input bit noise);
    bit b;
    int ns;
    ns = fr_s.size();
    if (noise) begin
      bus.STF_ERR = 1'b1;
      repeat (2) @(posedge clk);
    end
    for (int k = 0; k < ns; k++) begin
      b = fr_s[k];
      if (k == err_at) b = ~b;
      send_bit(b);
      if (k == 0) bus.STF_ERR = 1'b0;
      if (k == err_at) begin
        chk("viol_err", bus.ERR, 1);
        chk("viol_f_stf", bus.F_STF, 0);
        chk("viol_busy", bus.BUSY, 1);
        chk("viol_stuff", bus.STUFF_BIT, 0);
        chk("viol_valid", bus.BIT_VALID, 0);
        err_recover();
        return;
      end
      chk("stuff_bit", bus.STUFF_BIT, fr_stf[k]);
      chk("bit_valid", bus.BIT_VALID, !fr_stf[k]);
      if (!fr_stf[k]) begin
        chk("bit_idx", bus.BIT_IDX, fr_idx[k]);
        chk("bit_out", bus.BIT_OUT, b);
      end
      chk("f_stf", bus.F_STF, (k < ns - 1));
      chk("busy", bus.BUSY, 1);
      chk("err", bus.ERR, 0);
      chk("frame_ok", bus.FRAME_OK, 0);
      if (!fr_stf[k] && fr_idx[k] == stf_idx) begin
        bus.STF_ERR = 1'b1;
        @(posedge clk);
        #1;
        bus.STF_ERR = 1'b0;
        chk("stf_err_err", bus.ERR, 1);
        chk("stf_err_f_stf", bus.F_STF, 0);
        chk("stf_err_busy", bus.BUSY, 1);
        err_recover();
        return;
      end
    end
    if (noise) bus.STF_ERR = 1'b1;
    for (int t = 0; t < TAIL_BITS; t++) begin
      send_bit(1'b1);
      chk("tail_valid", bus.BIT_VALID, 1);
      chk("tail_idx", bus.BIT_IDX, fr_last + 1 + t);
      chk("tail_out", bus.BIT_OUT, 1);
      chk("tail_f_stf", bus.F_STF, 0);
      chk("tail_stuff", bus.STUFF_BIT, 0);
      chk("tail_err", bus.ERR, 0);
      chk("tail_frame_ok", bus.FRAME_OK, (t == TAIL_BITS - 1));
      chk("tail_busy", bus.BUSY, (t != TAIL_BITS - 1));
    end
    bus.STF_ERR = 1'b0;
    chk("ide_out", bus.IDE_OUT, fr_ide);
    chk("dlc", bus.DLC, fr_dlc);
  endtask

  initial begin
    int stuff_pos[$];
    int mode;
    int err_at;
    int stf_idx;
    bit ide;
    total = 0;
    bad   = 0;
    bus.SP      = 1'b0;
    bus.RX      = 1'b1;
    bus.STF_ERR = 1'b0;
    reset       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    go_idle();

    // Asynchronous reset in the middle of a frame.
    build_frame(1'b0, 1'b0, 2, 29'($urandom), {$urandom, $urandom}, 15'($urandom));
    for (int k = 0; k < 24; k++) send_bit(fr_s[k]);
    chk("pre_reset_busy", bus.BUSY, 1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    go_idle();
    run_frame(-1, -1, 1'b0);

    // Standard frame ID 0, DLC 1, data 0x55; then the stuff bit after SOF+4 zeros broken.
    build_frame(1'b0, 1'b0, 1, 29'd0, 64'h5500_0000_0000_0000, 15'($urandom));
    run_frame(-1, -1, 1'b0);
    @(posedge clk);
    #1;
    chk("frame_ok_width", bus.FRAME_OK, 0);
    run_frame(5, -1, 1'b0);

    // Extended remote frame with DLC 8.
    build_frame(1'b1, 1'b1, 8, 29'($urandom), {$urandom, $urandom}, 15'($urandom));
    run_frame(-1, -1, 1'b0);

    // CRC ending in five zeros needs a trailing stuff bit; then that bit broken.
    build_frame(1'b0, 1'b0, 3, 29'($urandom), {$urandom, $urandom},
                {9'($urandom), 1'b1, 5'b00000});
    run_frame(-1, -1, 1'b0);
    run_frame(fr_s.size() - 1, -1, 1'b0);

    // STF_ERR ignored in IDLE and TAIL, honoured in STUFFED.
    build_frame(1'b1, 1'b0, 2, 29'($urandom), {$urandom, $urandom}, 15'($urandom));
    run_frame(-1, -1, 1'b1);
    run_frame(-1, 7, 1'b0);

    for (int f = 0; f < 24; f++) begin
      ide = 1'($urandom);
      build_frame(ide, 1'($urandom), int'($urandom_range(0, 15)), 29'($urandom),
                  {$urandom, $urandom}, 15'($urandom));
      mode    = int'($urandom_range(0, 3));
      err_at  = -1;
      stf_idx = -1;
      if (mode == 2) begin
        stuff_pos.delete();
        for (int k = 0; k < fr_s.size(); k++) if (fr_stf[k]) stuff_pos.push_back(k);
        if (stuff_pos.size() > 0)
          err_at = stuff_pos[$urandom_range(0, stuff_pos.size() - 1)];
      end else if (mode == 3) begin
        stf_idx = int'($urandom_range(0, fr_last - 1));
      end
      run_frame(err_at, stf_idx, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
